// File: rtl/lmx2581_pkg.sv
// Shared definitions for the LMX2581 word sequencer.
//   LMX_WORD_W    : width of one LMX2581 register word
//   DEF_*         : default parameter values for the sequencer and FIFO
//   seq_state_e   : one-hot sequencer FSM state encoding
package lmx2581_pkg;

  localparam int LMX_WORD_W   = 32;
  localparam int DEF_FIFO_AW  = 4;
  localparam int DEF_GAP_BITS = 16;
  localparam int DEF_CNT_BITS = 16;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_ISSUE     = 4'b0010,
    ST_WAIT_DONE = 4'b0100,
    ST_GAP       = 4'b1000
  } seq_state_e;

endpackage

// File: rtl/lmx2581_word_sequencer_if.sv
// Handshake between the word sequencer and the LMX2581 SPI engine.
//   word_o       : register word offered to the SPI engine
//   word_valid_o : word_o is valid
//   word_ready_i : SPI engine idle and able to accept
//   word_done_i  : one-cycle pulse when the SPI transaction finishes
// Modports: master = sequencer side, slave = SPI engine side.
interface lmx2581_word_sequencer_if import lmx2581_pkg::*; ();

  logic [LMX_WORD_W-1:0] word_o;
  logic                  word_valid_o;
  logic                  word_ready_i;
  logic                  word_done_i;

  modport master (
    output word_o,
    output word_valid_o,
    input  word_ready_i,
    input  word_done_i
  );

  modport slave (
    input  word_o,
    input  word_valid_o,
    output word_ready_i,
    output word_done_i
  );

endinterface

// File: rtl/lmx2581_word_fifo.sv
// Single-clock word FIFO with registered pop data.
//   clk, rst          : clock, asynchronous active-high reset
//   clr_i             : synchronous flush (also clears the overflow flag)
//   push_i/push_data_i: write request and data; dropped when full unless popping
//   pop_i             : read request; rd_data_o updates on the next edge
//   count_o/full_o/empty_o : occupancy status
//   overflow_o        : sticky, set when a push is dropped
module lmx2581_word_fifo import lmx2581_pkg::*; #(
  parameter int AW = DEF_FIFO_AW,
  parameter int DW = LMX_WORD_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] rd_data_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          overflow_o
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          ovf_q, ovf_d;
  logic          full_s, empty_s, push_ok_s, pop_ok_s;

  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == {(AW+1){1'b0}});
  assign pop_ok_s  = pop_i & ~empty_s;
  // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
  assign push_ok_s = push_i & (~full_s | pop_ok_s);

  // Next-state for pointers, occupancy, pop data and overflow flag.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    ovf_d     = ovf_q;
    if (clr_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
      ovf_d    = 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        rd_data_d = mem_q[rd_ptr_q];
      end else begin
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      if (push_i && !push_ok_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  // Control and pop-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {(AW+1){1'b0}};
      rd_data_q <= {DW{1'b0}};
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage array; needs no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s && !clr_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign count_o    = count_q;
  assign full_o     = full_s;
  assign empty_o    = empty_s;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/lmx2581_word_sequencer.sv
// Feeds buffered LMX2581 register words to the SPI engine one at a time,
// waiting for each transaction to finish plus a programmable idle gap.
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   push_i/push_data_i : write a word into the FIFO
//   clear_i            : synchronous flush of FIFO, FSM, overflow and sent count
//   run_i              : while high, the FIFO drains to the SPI engine
//   gap_cycles_i       : idle clocks after each word_done_i (sampled on the pulse)
//   spi                : word/valid/ready/done handshake to the SPI engine
//   fifo_count_o/fifo_full_o/overflow_o : FIFO status
//   busy_o             : transaction in progress or words pending
//   words_sent_o       : accepted handshakes, wrapping
module lmx2581_word_sequencer import lmx2581_pkg::*; #(
  parameter int FIFO_AW  = DEF_FIFO_AW,
  parameter int GAP_BITS = DEF_GAP_BITS,
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  push_i,
  input  logic [LMX_WORD_W-1:0] push_data_i,
  input  logic                  clear_i,
  input  logic                  run_i,
  input  logic [GAP_BITS-1:0]   gap_cycles_i,
  lmx2581_word_sequencer_if.master spi,
  output logic [FIFO_AW:0]      fifo_count_o,
  output logic                  fifo_full_o,
  output logic                  overflow_o,
  output logic                  busy_o,
  output logic [CNT_BITS-1:0]   words_sent_o
);

  seq_state_e            state_q, state_d;
  logic                  valid_q, valid_d;
  logic [GAP_BITS-1:0]   gap_q, gap_d;
  logic [CNT_BITS-1:0]   sent_q, sent_d;
  logic                  pop_s;
  logic                  fifo_empty_s;
  logic [LMX_WORD_W-1:0] fifo_rd_data_s;

  lmx2581_word_fifo #(
    .AW (FIFO_AW),
    .DW (LMX_WORD_W)
  ) u_fifo (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .clr_i       (clear_i),
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .pop_i       (pop_s),
    .rd_data_o   (fifo_rd_data_s),
    .count_o     (fifo_count_o),
    .full_o      (fifo_full_o),
    .empty_o     (fifo_empty_s),
    .overflow_o  (overflow_o)
  );

  // Sequencer next-state, pop request, gap countdown and sent counter.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    gap_d   = gap_q;
    sent_d  = sent_q;
    pop_s   = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      gap_d   = {GAP_BITS{1'b0}};
      sent_d  = {CNT_BITS{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run_i && !fifo_empty_s) begin
            pop_s   = 1'b1;
            valid_d = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // Once offered, the word is never withdrawn, even if run_i drops.
          if (spi.word_ready_i) begin
            valid_d = 1'b0;
            sent_d  = sent_q + CNT_BITS'(1);
            state_d = ST_WAIT_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_WAIT_DONE: begin
          if (spi.word_done_i) begin
            if (gap_cycles_i == {GAP_BITS{1'b0}}) begin
              state_d = ST_IDLE;
            end else begin
              gap_d   = gap_cycles_i;
              state_d = ST_GAP;
            end
          end else begin
            state_d = ST_WAIT_DONE;
          end
        end
        ST_GAP: begin
          // Leaving at 1 yields exactly gap_cycles_i clocks from done to IDLE.
          if (gap_q <= GAP_BITS'(1)) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q - GAP_BITS'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      gap_q   <= {GAP_BITS{1'b0}};
      sent_q  <= {CNT_BITS{1'b0}};
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      gap_q   <= gap_d;
      sent_q  <= sent_d;
    end
  end

  // The FIFO's registered pop data doubles as the held output word.
  assign spi.word_o       = fifo_rd_data_s;
  assign spi.word_valid_o = valid_q;
  assign busy_o           = (state_q != ST_IDLE) | ~fifo_empty_s;
  assign words_sent_o     = sent_q;

endmodule

// File: tb/tb_lmx2581_word_sequencer.sv
module tb_lmx2581_word_sequencer;
  import lmx2581_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [31:0] pdata;
  logic        clear;
  logic        run;
  logic [15:0] gap;
  logic [4:0]  cnt;
  logic        full;
  logic        ovf;
  logic        busy;
  logic [15:0] sent;

  lmx2581_word_sequencer_if spi_if ();

  lmx2581_word_sequencer dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .push_i       (push),
    .push_data_i  (pdata),
    .clear_i      (clear),
    .run_i        (run),
    .gap_cycles_i (gap),
    .spi          (spi_if),
    .fifo_count_o (cnt),
    .fifo_full_o  (full),
    .overflow_o   (ovf),
    .busy_o       (busy),
    .words_sent_o (sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: words the DUT must hand out in order, and expected counters.
  logic [31:0] exp_q[$];
  int          m_sent = 0;
  bit          m_ovf  = 1'b0;

  typedef struct {
    logic [31:0] data;
    int          exp_count;
    bit          exp_full;
    bit          exp_ovf;
  } ovf_vec_t;
  ovf_vec_t ovf_tbl[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one word; model applies the capacity rule (only used when nothing pops).
  task automatic push_word(input logic [31:0] d);
    push  = 1'b1;
    pdata = d;
    tick();
    push  = 1'b0;
    if (exp_q.size() < 16) exp_q.push_back(d);
    else m_ovf = 1'b1;
  endtask

  // Wait for the next offered word, check it, hold off ready, accept, then return done.
  task automatic serve(input int rdy_dly, input int done_dly, input bit drop_run);
    int k;
    logic [31:0] w;
    w = exp_q.pop_front();
    k = 0;
    while (spi_if.word_valid_o !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    chk("valid_seen", {63'd0, spi_if.word_valid_o}, 64'd1);
    chk("word_order", {32'd0, spi_if.word_o}, {32'd0, w});
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      chk("bp_word", {32'd0, spi_if.word_o}, {32'd0, w});
      chk("bp_valid", {63'd0, spi_if.word_valid_o}, 64'd1);
      chk("bp_sent", {48'd0, sent}, 64'(m_sent));
    end
    spi_if.word_ready_i = 1'b1;
    tick();
    spi_if.word_ready_i = 1'b0;
    m_sent++;
    chk("valid_drop", {63'd0, spi_if.word_valid_o}, 64'd0);
    chk("sent_inc", {48'd0, sent}, 64'(m_sent));
    if (drop_run) run = 1'b0;
    repeat (done_dly) tick();
    spi_if.word_done_i = 1'b1;
    tick();
    spi_if.word_done_i = 1'b0;
  endtask

  // Clocks from the done pulse until word_valid_o rises must be gap+1.
  task automatic measure_gap(input int g);
    int k;
    k = 0;
    while (spi_if.word_valid_o !== 1'b1 && k < 1000) begin
      tick();
      k++;
    end
    chk("gap_spacing", 64'(k), 64'(g + 1));
  endtask

  initial begin
    int g;
    int n;
    rst = 1'b1; push = 1'b0; pdata = 32'd0; clear = 1'b0; run = 1'b0; gap = 16'd0;
    spi_if.word_ready_i = 1'b0;
    spi_if.word_done_i  = 1'b0;
    #2;
    chk("rst_word", {32'd0, spi_if.word_o}, 64'd0);
    chk("rst_valid", {63'd0, spi_if.word_valid_o}, 64'd0);
    chk("rst_count", {59'd0, cnt}, 64'd0);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sent", {48'd0, sent}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic drain.
    run = 1'b1;
    push_word(32'h0000_0005);
    push_word(32'h1234_567A);
    serve(0, 39, 1'b0);
    serve(0, 39, 1'b0);
    chk("basic_sent", {48'd0, sent}, 64'd2);
    chk("basic_count", {59'd0, cnt}, 64'd0);
    chk("basic_busy", {63'd0, busy}, 64'd0);

    // Gap timing with backpressure on the middle word.
    run = 1'b0;
    gap = 16'd100;
    push_word(32'hA000_0001);
    push_word(32'hA000_0002);
    push_word(32'hA000_0003);
    run = 1'b1;
    serve(0, 3, 1'b0);
    measure_gap(100);
    serve(50, 3, 1'b0);
    measure_gap(100);
    serve(0, 3, 1'b0);
    repeat (99) tick();
    chk("gap_busy_end", {63'd0, busy}, 64'd1);
    tick();
    chk("gap_idle", {63'd0, busy}, 64'd0);
    chk("gap_no_valid", {63'd0, spi_if.word_valid_o}, 64'd0);

    // Overflow table: 17 pushes with run low into a 16-deep FIFO.
    run = 1'b0;
    gap = 16'd0;
    for (int i = 0; i < 17; i++) begin
      ovf_tbl[i].data      = $urandom;
      ovf_tbl[i].exp_count = (i + 1 > 16) ? 16 : i + 1;
      ovf_tbl[i].exp_full  = (i >= 15);
      ovf_tbl[i].exp_ovf   = (i == 16);
    end
    for (int i = 0; i < 17; i++) begin
      push_word(ovf_tbl[i].data);
      chk("ovf_count", {59'd0, cnt}, 64'(ovf_tbl[i].exp_count));
      chk("ovf_full", {63'd0, full}, {63'd0, ovf_tbl[i].exp_full});
      chk("ovf_flag", {63'd0, ovf}, {63'd0, ovf_tbl[i].exp_ovf});
    end
    // Push while full in the same cycle as the first pop.
    run   = 1'b1;
    push  = 1'b1;
    pdata = 32'hFEED_0017;
    tick();
    push  = 1'b0;
    exp_q.push_back(32'hFEED_0017);
    chk("full_pushpop_count", {59'd0, cnt}, 64'd16);
    chk("full_pushpop_ovf", {63'd0, ovf}, 64'd1);
    for (int i = 0; i < 17; i++) serve($urandom_range(0, 2), $urandom_range(0, 4), 1'b0);
    tick();
    chk("ovf_drain_count", {59'd0, cnt}, 64'd0);
    chk("ovf_drain_busy", {63'd0, busy}, 64'd0);
    chk("ovf_drain_sent", {48'd0, sent}, 64'(m_sent));

    // Run gating: run drops during WAIT_DONE, second word must stay queued.
    run = 1'b0;
    push_word(32'hB000_0001);
    push_word(32'hB000_0002);
    run = 1'b1;
    gap = 16'd3;
    serve(0, 5, 1'b1);
    repeat (20) tick();
    chk("gate_valid", {63'd0, spi_if.word_valid_o}, 64'd0);
    chk("gate_count", {59'd0, cnt}, 64'd1);
    chk("gate_busy", {63'd0, busy}, 64'd1);
    chk("gate_sent", {48'd0, sent}, 64'(m_sent));
    for (int i = 0; i < 16; i++) push_word($urandom);
    chk("gate_ovf", {63'd0, ovf}, {63'd0, m_ovf});
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    m_sent = 0;
    m_ovf  = 1'b0;
    chk("clr_count", {59'd0, cnt}, 64'd0);
    chk("clr_ovf", {63'd0, ovf}, 64'd0);
    chk("clr_sent", {48'd0, sent}, 64'd0);
    chk("clr_busy", {63'd0, busy}, 64'd0);
    spi_if.word_done_i = 1'b1;
    tick();
    spi_if.word_done_i = 1'b0;
    repeat (5) tick();
    chk("stray_valid", {63'd0, spi_if.word_valid_o}, 64'd0);
    chk("stray_busy", {63'd0, busy}, 64'd0);
    chk("stray_sent", {48'd0, sent}, 64'd0);

    // Randomized rounds against the queue model.
    for (int r = 0; r < 3; r++) begin
      run = 1'b0;
      n = $urandom_range(4, 12);
      for (int i = 0; i < n; i++) push_word($urandom);
      run = 1'b1;
      for (int i = 0; i < n; i++) begin
        g   = $urandom_range(0, 6);
        gap = 16'(g);
        serve($urandom_range(0, 3), $urandom_range(0, 5), 1'b0);
        if (exp_q.size() > 0) measure_gap(g);
      end
      repeat (10) tick();
      chk("rnd_busy", {63'd0, busy}, 64'd0);
      chk("rnd_count", {59'd0, cnt}, 64'd0);
      chk("rnd_sent", {48'd0, sent}, 64'(m_sent));
    end

    // Asynchronous reset while counting out a gap.
    run = 1'b0;
    push_word(32'hC000_0001);
    push_word(32'hC000_0002);
    gap = 16'd50;
    run = 1'b1;
    serve(0, 2, 1'b0);
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_word", {32'd0, spi_if.word_o}, 64'd0);
    chk("arst_valid", {63'd0, spi_if.word_valid_o}, 64'd0);
    chk("arst_count", {59'd0, cnt}, 64'd0);
    chk("arst_full", {63'd0, full}, 64'd0);
    chk("arst_ovf", {63'd0, ovf}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_sent", {48'd0, sent}, 64'd0);
    exp_q.delete();
    m_sent = 0;
    tick();
    rst = 1'b0;
    repeat (60) tick();
    chk("post_rst_valid", {63'd0, spi_if.word_valid_o}, 64'd0);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lmx2581_word_sequencer.md
Name: lmx2581_word_sequencer

Overview:
- Upstream feeder for the LMX2581 SPI controller.
- Buffers a sequence of 32-bit LMX2581 register words written by software into a FIFO.
- Issues the words one at a time to the SPI engine over a valid/ready handshake.
- Waits for each SPI transaction to complete, then enforces a programmable inter-word gap before the next issue. The gap covers VCO calibration and settling after R0 writes.

Parameters:
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW words.
- GAP_BITS, 16, width of the inter-word gap counter.
- CNT_BITS, 16, width of the words-sent counter.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- push_i  in  1  one-cycle request to write push_data_i into the FIFO.
- push_data_i  in  32  register word (LMX2581 format, address in [3:0]).
- clear_i  in  1  synchronous flush of FIFO and sequencer; clears the overflow flag and the sent counter.
- run_i  in  1  level; while high, the FIFO is drained to the SPI engine.
- gap_cycles_i  in  GAP_BITS  idle clocks inserted after each word_done_i.
- word_o  out  32  word presented to the SPI engine.
- word_valid_o  out  1  word_o valid.
- word_ready_i  in  1  SPI engine idle and able to accept.
- word_done_i  in  1  one-cycle pulse when the SPI engine finishes a transaction (LE high then low).
- fifo_count_o  out  FIFO_AW+1  current occupancy.
- fifo_full_o  out  1  count == depth.
- overflow_o  out  1  sticky; a push was dropped.
- busy_o  out  1  state != IDLE or FIFO not empty.
- words_sent_o  out  CNT_BITS  count of accepted handshakes; wraps modulo 2**CNT_BITS.

Behaviour:
- Reset values (asynchronous, immediate on wb_rst_i): FIFO empty, state IDLE, word_o=0, word_valid_o=0, fifo_count_o=0, fifo_full_o=0, overflow_o=0, busy_o=0, words_sent_o=0.
- FIFO push:
  - push_i is accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the data is dropped and overflow_o is set on the next edge.
  - Count is updated by +1, -1 or 0 for push only, pop only, or both/neither.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
  - IDLE: if run_i && FIFO non-empty, pop the head into word_o, assert word_valid_o, go to ISSUE. Pop-to-valid latency is 1 clock.
  - ISSUE: hold word_o and word_valid_o stable until word_ready_i. On word_valid_o && word_ready_i: deassert valid next cycle, increment words_sent_o, go to WAIT_DONE. run_i dropping here does not withdraw the word.
  - WAIT_DONE: wait for word_done_i. On the pulse, load the gap counter with gap_cycles_i and go to GAP. If gap_cycles_i == 0, go directly to IDLE.
  - GAP: decrement each clock; go to IDLE when the counter reaches 1. Exactly gap_cycles_i idle clocks elapse between the done pulse and IDLE.
- Minimum spacing: word_done_i to the next word_valid_o rise is gap_cycles_i+1 clocks, if run_i is high and the FIFO is non-empty.
- word_done_i outside WAIT_DONE is ignored.
- gap_cycles_i is sampled only on the done pulse.
- run_i low: the current word completes fully (handshake, done, gap). The sequencer then remains in IDLE and the FIFO is retained.
- clear_i:
  - Takes priority over push, pop and FSM transitions.
  - Empties the FIFO, sets state IDLE, drops word_valid_o and zeroes words_sent_o and overflow_o.
  - Does not abort a transaction already inside the SPI engine; a late word_done_i is ignored.
- Reset mid-transaction: same as clear, asynchronous.
- word_o retains its last value when word_valid_o is low.

Decomposition:
- Package lmx2581_pkg: LMX_WORD_W=32, FSM state encodings (one-hot, 4 bits), default FIFO_AW/GAP_BITS.
- One sub-module: lmx2581_word_fifo (synchronous single-clock FIFO, async reset, push/pop/clear, count/full/empty; pop data registered).
- The sequencer FSM, gap counter and sent counter live in the top.

Test Plan:
- Basic drain: push 0x00000005 and 0x1234567A with run_i=1, gap=0, word_ready_i tied high, done returned 40 clocks after accept. Required: two handshakes in order, words_sent_o=2, FIFO empty, busy_o=0.
- Gap timing: gap_cycles_i=100, push 3 words, run_i=1. Required: word_valid_o rises exactly 101 clocks after each word_done_i.
- Backpressure: word_ready_i low for 50 clocks while word_valid_o=1. Required: word_o stable, no count change; accept on the first ready-high cycle.
- Overflow: FIFO_AW=4, run_i=0, push 17 words. Required: fifo_count_o=16, fifo_full_o=1, overflow_o=1, word 17 absent on drain. Simultaneous push+pop when full is accepted, count stays 16.
- Run gating and clear: drop run_i during WAIT_DONE. Required: the current word finishes, no further issue. Then assert clear_i for 1 cycle. Required: count=0, overflow_o=0, words_sent_o=0; a stray word_done_i has no effect.
- Async reset mid-GAP: assert wb_rst_i between clock edges. Required: all outputs at reset values immediately, before the next clock.
